// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine holding the Hi/Lo result registers.
// One result bit per RUN cycle: shift-add for multiply, restoring
// shift-subtract for divide, operating on magnitudes with sign fix-up after.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic             Op,
    input  logic             IsSigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic               div_zero_s;
    logic               op_r, sgn_r, res_neg_r, dvd_neg_r;
    logic [WIDTH-1:0]   a_r, b_r, mb_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r, dz_r;

    logic [WIDTH-1:0]   ma_s, mb_s, addend_s, diff_s, quot_s, rem_s;
    logic [WIDTH:0]     sum_s, trial_s;
    logic               ge_s;
    logic [2*WIDTH-1:0] acc_step_s, prod_neg_s;
    logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

    assign Hi      = hi_r;
    assign Lo      = lo_r;
    assign Busy    = busy_r;
    assign Done    = done_r;
    assign DivZero = dz_r;

    // Next-state decode; a divide by zero skips straight to DONE.
    always_comb begin
        state_s    = state_r;
        div_zero_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (Start) state_s = S_PREP;
                else       state_s = S_IDLE;
            end
            S_PREP: begin
                if (op_r && (b_r == ZERO_W)) begin
                    state_s    = S_DONE;
                    div_zero_s = 1'b1;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_r == CNT_LAST) state_s = S_FIX;
                else                   state_s = S_RUN;
            end
            S_FIX:   state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register plus registered handshake outputs derived from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == S_PREP) || (state_s == S_RUN) || (state_s == S_FIX);
            done_r  <= (state_s == S_DONE);
            dz_r    <= div_zero_s;
        end
    end

    // Datapath arithmetic: magnitudes, one iteration step, and final sign fix-up.
    always_comb begin
        ma_s     = (sgn_r && a_r[WIDTH-1]) ? (~a_r + ONE_W) : a_r;
        mb_s     = (sgn_r && b_r[WIDTH-1]) ? (~b_r + ONE_W) : b_r;
        addend_s = acc_r[0] ? mb_r : ZERO_W;
        sum_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
        // Divide: acc holds {remainder, quotient}; trial is the remainder shifted left by one.
        trial_s  = acc_r[2*WIDTH-1:WIDTH-1];
        ge_s     = (trial_s >= {1'b0, mb_r});
        diff_s   = trial_s[WIDTH-1:0] - mb_r;
        if (op_r) begin
            acc_step_s = {(ge_s ? diff_s : trial_s[WIDTH-1:0]), acc_r[WIDTH-2:0], ge_s};
        end else begin
            acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
        end
        prod_neg_s = ~acc_r + ONE_2W;
        quot_s     = acc_r[WIDTH-1:0];
        rem_s      = acc_r[2*WIDTH-1:WIDTH];
        if (op_r) begin
            fix_lo_s = res_neg_r ? (~quot_s + ONE_W) : quot_s;
            fix_hi_s = dvd_neg_r ? (~rem_s + ONE_W) : rem_s;
        end else if (res_neg_r) begin
            fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_neg_s[WIDTH-1:0];
        end else begin
            fix_hi_s = acc_r[2*WIDTH-1:WIDTH];
            fix_lo_s = acc_r[WIDTH-1:0];
        end
    end

    // Operand capture, iteration registers and Hi/Lo update on entry to DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_r      <= 1'b0;
            sgn_r     <= 1'b0;
            a_r       <= ZERO_W;
            b_r       <= ZERO_W;
            mb_r      <= ZERO_W;
            acc_r     <= {ZERO_W, ZERO_W};
            cnt_r     <= CNT_ZERO;
            res_neg_r <= 1'b0;
            dvd_neg_r <= 1'b0;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (Start) begin
                        op_r  <= Op;
                        sgn_r <= IsSigned;
                        a_r   <= A;
                        b_r   <= B;
                    end
                end
                S_PREP: begin
                    mb_r      <= mb_s;
                    acc_r     <= {ZERO_W, ma_s};
                    cnt_r     <= CNT_ZERO;
                    res_neg_r <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    dvd_neg_r <= sgn_r & a_r[WIDTH-1];
                end
                S_RUN: begin
                    acc_r <= acc_step_s;
                    cnt_r <= (cnt_r == CNT_LAST) ? CNT_ZERO : (cnt_r + CNT_ONE);
                end
                S_FIX: begin
                    hi_r <= fix_hi_s;
                    lo_r <= fix_lo_s;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
